// File: rtl/jericalla_pkg.sv
// Shared definitions for the Jericalla fetch/issue front end: instruction
// field layout, bubble word, writer mask and the issue FSM states.
package jericalla_pkg;

    localparam int IW      = 17;
    localparam int REG_W   = 5;
    localparam int OP_LSB  = 15;
    localparam int WA_LSB  = 10;
    localparam int RA1_LSB = 5;
    localparam int RA2_LSB = 0;

    // Bit n set: opcode n writes the register bank.
    localparam logic [3:0]    WR_MASK  = 4'b0111;
    localparam logic [IW-1:0] NOP_WORD = 17'h18000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [1:0] op_of(input logic [IW-1:0] w);
        return w[OP_LSB +: 2];
    endfunction

    function automatic logic [REG_W-1:0] wa_of(input logic [IW-1:0] w);
        return w[WA_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] ra1_of(input logic [IW-1:0] w);
        return w[RA1_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] ra2_of(input logic [IW-1:0] w);
        return w[RA2_LSB +: REG_W];
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Tracks the write addresses of the last two issued words and flags a
// read-after-write conflict for the word waiting at the program counter.
module hazard_scoreboard #(
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          shift_i,
    input  logic [RW-1:0] wa_i,
    input  logic          wr_i,
    input  logic [RW-1:0] ra1_i,
    input  logic [RW-1:0] ra2_i,
    output logic          hazard_o
);

    logic [RW-1:0] s1_wa_q, s2_wa_q;
    logic          s1_v_q, s2_v_q;
    logic          hit1, hit2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_wa_q <= '0;
            s2_wa_q <= '0;
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
        end else if (clear_i) begin
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
        end else if (shift_i) begin
            s2_wa_q <= s1_wa_q;
            s2_v_q  <= s1_v_q;
            s1_wa_q <= wa_i;
            s1_v_q  <= wr_i;
        end
    end

    // Register 0 is an ordinary register here; no zero-register exemption.
    assign hit1     = s1_v_q && ((ra1_i == s1_wa_q) || (ra2_i == s1_wa_q));
    assign hit2     = s2_v_q && ((ra1_i == s2_wa_q) || (ra2_i == s2_wa_q));
    assign hazard_o = hit1 || hit2;

endmodule

// File: rtl/fetch_issue_unit.sv
// Program memory, program counter and issue FSM feeding the Jericalla
// pipeline; inserts bubbles on RAW hazards and drains before signalling done.
module fetch_issue_unit
    import jericalla_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int AW        = 6,
    parameter int DRAIN_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic [AW:0]   num_instr,
    input  logic          start,
    output logic [IW-1:0] instruccion,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic [7:0]    stall_cnt
);

    localparam int         DCW     = $clog2(DRAIN_CYC + 1);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [IW-1:0]  mem_q [DEPTH];

    state_e         state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [AW:0]    len_q, len_d;
    logic [IW-1:0]  instr_q, instr_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [7:0]     stall_q, stall_d;
    logic [DCW-1:0] drain_q, drain_d;

    logic [IW-1:0]  mem_word;
    logic [AW:0]    len_start;
    logic           last_issue;
    logic           hazard;
    logic           sb_clear;

    // Loading is locked out for the whole run so the program cannot change under the PC.
    always_ff @(posedge clk) begin
        if (prog_we && !busy_q) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign mem_word   = mem_q[pc_q];
    assign len_start  = (num_instr > DEPTH_L) ? DEPTH_L : num_instr;
    assign last_issue = ({1'b0, pc_q} == (len_q - 1'b1));

    hazard_scoreboard #(
        .RW (REG_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (sb_clear),
        .shift_i  (busy_q),
        .wa_i     (wa_of(instr_d)),
        .wr_i     (WR_MASK[op_of(instr_d)]),
        .ra1_i    (ra1_of(mem_word)),
        .ra2_i    (ra2_of(mem_word)),
        .hazard_o (hazard)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        instr_d  = instr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        stall_d  = stall_q;
        drain_d  = drain_q;
        sb_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sb_clear = 1'b1;
                    len_d    = len_start;
                    stall_d  = '0;
                    pc_d     = '0;
                    busy_d   = 1'b1;
                    if (len_start != '0) begin
                        state_d = RUN;
                        drain_d = '0;
                    end else begin
                        // Empty program: counter preset so DONE follows on the next edge.
                        state_d = DRAIN;
                        drain_d = DCW'(DRAIN_CYC);
                    end
                end
            end
            RUN: begin
                if (hazard) begin
                    instr_d = NOP_WORD;
                    stall_d = (stall_q == 8'hFF) ? stall_q : stall_q + 8'd1;
                end else begin
                    instr_d = mem_word;
                    pc_d    = pc_q + 1'b1;
                    if (last_issue) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                instr_d = NOP_WORD;
                if (drain_q == DCW'(DRAIN_CYC)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            DONE: begin
                instr_d = NOP_WORD;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            instr_q <= NOP_WORD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            stall_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            instr_q <= instr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            stall_q <= stall_d;
            drain_q <= drain_d;
        end
    end

    assign instruccion = instr_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Self-checking bench for fetch_issue_unit: directed programs with hand-derived
// issue sequences plus random programs checked against a small issue model.
module tb_fetch_issue_unit;
    import jericalla_pkg::*;

    localparam int DEPTH     = 64;
    localparam int AW        = 6;
    localparam int DRAIN_CYC = 2;

    localparam logic [IW-1:0] I0    = 17'b00_00011_00001_00010;
    localparam logic [IW-1:0] I1    = 17'b00_00100_00101_00110;
    localparam logic [IW-1:0] I2    = 17'b01_00111_01000_01001;
    localparam logic [IW-1:0] RD3   = 17'b01_00100_00011_00001;
    localparam logic [IW-1:0] RD3B  = 17'b01_00111_01000_00011;
    localparam logic [IW-1:0] NWR   = 17'b11_00011_00001_00010;
    localparam logic [IW-1:0] NEW0  = 17'b10_01010_01011_01100;
    localparam logic [IW-1:0] JUNK  = 17'h1F0F0;

    logic          clk;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic [AW:0]   num_instr;
    logic          start;
    logic [IW-1:0] instruccion;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic [7:0]    stall_cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [IW-1:0] exp_q[$];
    logic [AW-1:0] exp_pc_q[$];
    logic [IW-1:0] prog_img [DEPTH];

    fetch_issue_unit #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .num_instr   (num_instr),
        .start       (start),
        .instruccion (instruccion),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [IW-1:0] w, input logic [AW-1:0] p);
        exp_q.push_back(w);
        exp_pc_q.push_back(p);
    endtask

    function automatic bit raw(input logic [IW-1:0] w, input logic [IW-1:0] s);
        logic [3:0] mask;
        mask = 4'b0111;
        return mask[s[16:15]] && ((w[9:5] == s[14:10]) || (w[4:0] == s[14:10]));
    endfunction

    // Reference issue model: pushes the expected word/pc stream for a run.
    task automatic model_run(input int len, output logic [7:0] stalls);
        logic [IW-1:0] s1, s2, w, iss;
        int pcm, st;
        s1 = 17'h18000;
        s2 = 17'h18000;
        pcm = 0;
        st = 0;
        while (pcm < len) begin
            w = prog_img[pcm];
            if (raw(w, s1) || raw(w, s2)) begin
                iss = 17'h18000;
                st++;
            end else begin
                iss = w;
                pcm++;
            end
            push_exp(iss, AW'(pcm % DEPTH));
            s2 = s1;
            s1 = iss;
        end
        repeat (DRAIN_CYC + 1) push_exp(17'h18000, AW'(pcm % DEPTH));
        stalls = (st > 255) ? 8'd255 : 8'(st);
    endtask

    task automatic load_prog(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = AW'(i);
            prog_data = prog_img[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Starts a run and compares every cycle against the expected queue;
    // the last queued entry is the cycle in which done must pulse.
    task automatic run_prog(input logic [AW:0] n, input logic [7:0] exp_stall,
                            input bit meddle, input bit wr_with_start,
                            input logic [IW-1:0] wr_data, input string name);
        int total;
        logic [IW-1:0] e;
        logic [AW-1:0] ep;
        total = exp_q.size();
        @(negedge clk);
        start     = 1'b1;
        num_instr = n;
        if (wr_with_start) begin
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = wr_data;
        end
        @(negedge clk);
        start     = 1'b0;
        prog_we   = 1'b0;
        num_instr = '0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_start got %b want 1", name, busy);
        end
        for (int k = 1; k <= total; k++) begin
            if (meddle && k == 1) begin
                start     = 1'b1;
                num_instr = 7'd5;
                prog_we   = 1'b1;
                prog_addr = '0;
                prog_data = JUNK;
            end
            if (meddle && k == 2) begin
                start   = 1'b0;
                prog_we = 1'b0;
            end
            @(negedge clk);
            e  = exp_q.pop_front();
            ep = exp_pc_q.pop_front();
            vectors += 4;
            if (instruccion !== e) begin
                miscompares++;
                $display("FAIL %s instr cycle %0d got %h want %h", name, k, instruccion, e);
            end
            if (pc !== ep) begin
                miscompares++;
                $display("FAIL %s pc cycle %0d got %0d want %0d", name, k, pc, ep);
            end
            if (done !== (k == total)) begin
                miscompares++;
                $display("FAIL %s done cycle %0d got %b want %b", name, k, done, (k == total));
            end
            if (busy !== (k != total)) begin
                miscompares++;
                $display("FAIL %s busy cycle %0d got %b want %b", name, k, busy, (k != total));
            end
        end
        start   = 1'b0;
        prog_we = 1'b0;
        vectors++;
        if (stall_cnt !== exp_stall) begin
            miscompares++;
            $display("FAIL %s stall_cnt got %0d want %0d", name, stall_cnt, exp_stall);
        end
        @(negedge clk);
        vectors += 2;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_after got %b want 0", name, done);
        end
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_after got %b want 0", name, busy);
        end
    endtask

    task automatic check_reset_values(input string name);
        vectors += 5;
        if (instruccion !== NOP_WORD) begin
            miscompares++;
            $display("FAIL %s instr got %h want %h", name, instruccion, NOP_WORD);
        end
        if (pc !== '0) begin
            miscompares++;
            $display("FAIL %s pc got %0d want 0", name, pc);
        end
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy got %b want 0", name, busy);
        end
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done got %b want 0", name, done);
        end
        if (stall_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL %s stall_cnt got %0d want 0", name, stall_cnt);
        end
    endtask

    task automatic load_independent();
        prog_img[0] = I0;
        prog_img[1] = I1;
        prog_img[2] = I2;
        load_prog(3);
    endtask

    task automatic push_independent(input logic [IW-1:0] first);
        push_exp(first, 6'd1);
        push_exp(I1, 6'd2);
        push_exp(I2, 6'd3);
        push_exp(NOP_WORD, 6'd3);
        push_exp(NOP_WORD, 6'd3);
        push_exp(NOP_WORD, 6'd3);
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        num_instr = '0;
        start     = 1'b0;
        #1 rst = 1'b1;
        #2 check_reset_values("reset_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset_release");
    endtask

    task automatic test_independent();
        load_independent();
        push_independent(I0);
        run_prog(7'd3, 8'd0, 1'b0, 1'b0, '0, "independent");
    endtask

    task automatic test_raw_dist1();
        prog_img[0] = I0;
        prog_img[1] = RD3;
        load_prog(2);
        push_exp(I0, 6'd1);
        push_exp(NOP_WORD, 6'd1);
        push_exp(NOP_WORD, 6'd1);
        push_exp(RD3, 6'd2);
        push_exp(NOP_WORD, 6'd2);
        push_exp(NOP_WORD, 6'd2);
        push_exp(NOP_WORD, 6'd2);
        run_prog(7'd2, 8'd2, 1'b0, 1'b0, '0, "raw_dist1");
    endtask

    task automatic test_raw_dist2();
        prog_img[0] = I0;
        prog_img[1] = I1;
        prog_img[2] = RD3B;
        load_prog(3);
        push_exp(I0, 6'd1);
        push_exp(I1, 6'd2);
        push_exp(NOP_WORD, 6'd2);
        push_exp(RD3B, 6'd3);
        push_exp(NOP_WORD, 6'd3);
        push_exp(NOP_WORD, 6'd3);
        push_exp(NOP_WORD, 6'd3);
        run_prog(7'd3, 8'd1, 1'b0, 1'b0, '0, "raw_dist2");
    endtask

    task automatic test_non_writer();
        prog_img[0] = NWR;
        prog_img[1] = RD3;
        load_prog(2);
        push_exp(NWR, 6'd1);
        push_exp(RD3, 6'd2);
        push_exp(NOP_WORD, 6'd2);
        push_exp(NOP_WORD, 6'd2);
        push_exp(NOP_WORD, 6'd2);
        run_prog(7'd2, 8'd0, 1'b0, 1'b0, '0, "non_writer");
    endtask

    task automatic test_reset_restart();
        load_independent();
        @(negedge clk);
        start     = 1'b1;
        num_instr = 7'd3;
        @(negedge clk);
        start     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check_reset_values("reset_midrun");
        @(negedge clk);
        rst = 1'b0;
        push_independent(I0);
        run_prog(7'd3, 8'd0, 1'b0, 1'b0, '0, "restart");
    endtask

    task automatic test_len_zero();
        push_exp(NOP_WORD, 6'd0);
        run_prog(7'd0, 8'd0, 1'b0, 1'b0, '0, "len_zero");
    endtask

    task automatic test_busy_ignored();
        load_independent();
        push_independent(I0);
        run_prog(7'd3, 8'd0, 1'b1, 1'b0, '0, "busy_meddle");
        push_independent(I0);
        run_prog(7'd3, 8'd0, 1'b0, 1'b0, '0, "busy_mem_kept");
    endtask

    task automatic test_write_with_start();
        load_independent();
        push_independent(NEW0);
        run_prog(7'd3, 8'd0, 1'b0, 1'b1, NEW0, "write_with_start");
    endtask

    task automatic test_back_to_back();
        logic [7:0] st;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 10; i++) begin
                prog_img[i] = {2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            end
            load_prog(10);
            model_run(10, st);
            run_prog(7'd10, st, 1'b0, 1'b0, '0, "back_to_back");
        end
    endtask

    task automatic test_clamp_wrap();
        logic [7:0] st;
        for (int i = 0; i < DEPTH; i++) begin
            prog_img[i] = {2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
        end
        load_prog(DEPTH);
        model_run(DEPTH, st);
        run_prog(7'd100, st, 1'b0, 1'b0, '0, "clamp_wrap");
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw_dist1();
        test_raw_dist2();
        test_non_writer();
        test_reset_restart();
        test_len_zero();
        test_busy_ignored();
        test_write_with_start();
        test_back_to_back();
        test_clamp_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_issue_unit.md
Name: fetch_issue_unit

Overview:
- Instruction producer for the two-register-stage Jericalla pipeline.
- Holds a loadable program memory and a program counter, and drives the 17-bit instruction word every cycle.
- Detects read-after-write hazards against the register bank write-back, which lands two stages later. On a hazard it inserts NOP bubbles.
- After the last instruction it drains the pipeline, then pulses done. This replaces file-driven stimulus as the instruction source.

Parameters:
- DEPTH, 64, program memory entries.
- AW, 6, program counter / address width (log2 DEPTH).
- IW, 17, instruction width: op[16:15], WA[14:10], RA1[9:5], RA2[4:0].
- WR_MASK, 4'b0111, bit n set means opcode n writes the register bank.
- NOP_WORD, 17'h18000, bubble word. Its opcode must have a WR_MASK bit of 0.
- DRAIN_CYC, 2, NOP cycles issued after the last instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- prog_we  in  1  program write strobe; ignored while busy=1.
- prog_addr  in  AW  program write address.
- prog_data  in  IW  program write data.
- num_instr  in  AW+1  program length; sampled on start; values above DEPTH clamp to DEPTH.
- start  in  1  begin execution from address 0; ignored while busy=1.
- instruccion  out  IW  registered instruction word to the pipeline.
- pc  out  AW  address of the next instruction to issue.
- busy  out  1  high from the start-accept cycle until done.
- done  out  1  one-cycle pulse at the end of the drain.
- stall_cnt  out  8  bubbles inserted for hazards in the current run; saturates at 255.

Behaviour:
- Reset (async): instruccion=NOP_WORD, pc=0, busy=0, done=0, stall_cnt=0, scoreboard cleared, state=IDLE. Memory contents are not reset.
- Memory: synchronous write on prog_we and !busy; asynchronous read at pc.
- Scoreboard holds the two most recently issued words:
  - s1 = the current instruccion.
  - s2 = the word issued one cycle earlier.
  - Each entry is valid when WR_MASK[op] = 1.
- hazard = (mem[pc].RA1 or mem[pc].RA2) equals a valid s1.WA or s2.WA. Register 0 gets no special treatment.
- Consequence: a consumer issues at least 3 cycles after its producer. Distance 1 costs 2 bubbles; distance 2 costs 1 bubble.
- States:
  - IDLE: on start, latch len = clamp(num_instr) and clear stall_cnt, pc and scoreboard. Set busy=1. Go to RUN if len>0, else DRAIN with the drain count preset to DRAIN_CYC (no program word is issued).
  - RUN, per edge, no hazard: instruccion <= mem[pc]; pc <= pc+1. When the issued index equals len-1, go to DRAIN.
  - RUN, per edge, hazard: instruccion <= NOP_WORD; pc holds; stall_cnt += 1 (saturating).
  - DRAIN: instruccion <= NOP_WORD for DRAIN_CYC edges, then go to DONE. With len=0 the drain is skipped and DONE follows the next edge.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. instruccion stays NOP_WORD.
- pc wraps from DEPTH-1 to 0 only when len=DEPTH. The final increment is harmless because the state leaves RUN.
- The scoreboard shifts on every edge while busy, including bubbles. Bubbles are never valid writers.
- start and prog_we in the same cycle while idle: the write takes effect and start is accepted. The first issue reads the updated memory.
- Reset mid-run aborts immediately with the reset values. A later start reruns from address 0.

Decomposition:
- Package jericalla_pkg:
  - Field position constants OP/WA/RA1/RA2.
  - IW, NOP_WORD, WR_MASK.
  - State enum IDLE/RUN/DRAIN/DONE.
- One sub-module, hazard_scoreboard: two-entry WA/valid shift register plus the combinational compare, outputting hazard.
- Top level: memory, FSM, pc, counters.

Test Plan:
- Independent program, num_instr=3:
  - Program: I0=00_00011_00001_00010, I1=00_00100_00101_00110, I2=01_00111_01000_01001.
  - Start at edge 0 -> issued on edges 1,2,3.
  - NOP_WORD on edges 4,5; done pulse after edge 6; stall_cnt=0.
- Distance-1 RAW, num_instr=2:
  - Program: I0 writes r3; I1=01_00100_00011_00001 reads r3.
  - Expected sequence: I0, NOP, NOP, I1, then 2 drain NOPs; stall_cnt=2; pc holds at 1 during the bubbles.
- Distance-2 RAW: I0 writes r3, I1 independent, I2 reads r3 on RA2 -> I0, I1, NOP, I2; stall_cnt=1.
- Non-writing producer: I0 op=11 with WA=r3, I1 reads r3 -> no bubble; stall_cnt=0.
- Reset and restart:
  - Assert rst mid-RUN -> instruccion=NOP_WORD, pc=0, busy=0 without waiting for a clock edge.
  - start again -> first issued word is mem[0].
- Edge cases:
  - num_instr=0 -> busy for one cycle, then a done pulse; only NOP_WORD is observed.
  - start while busy is ignored.
  - prog_we while busy leaves memory unchanged.
